arb2to1_32bit: RTL and testbench
================================

# arb2to1_32bit

Two-requester, round-robin bus arbiter that sequences the shared 32-bit 2:1 datapath mux. It decides each cycle which of two valid/ready sources may drive the mux, registers the selected word into a single-entry output stage, and exposes the select of the held word. Long streams from one source are bounded by a burst limit so that neither source starves. The block sits between two producers and one consumer in the lab datapath.

## Interface
- WIDTH, 32: data width of both inputs and the output.
- MAX_BURST, 4: maximum consecutive words granted to one source while the other is waiting. Legal range is 1..15.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in1_valid  in  1  source 1 offers in1_data.
- in1_data  in  WIDTH  source 1 word.
- in1_ready  out  1  source 1 word accepted this cycle when high together with in1_valid.
- in2_valid  in  1  source 2 offers in2_data.
- in2_data  in  WIDTH  source 2 word.
- in2_ready  out  1  source 2 accept, with the same rule as in1_ready.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered mux output.
- out_ready  in  1  consumer takes out_data this cycle.
- sel  out  1  source of the word in the output register: 0 = in1, 1 = in2.

## Operation
- Internal state:
  - `state`: one of IDLE, OWN1, OWN2.
  - `bcnt`: burst count, 4 bits.
  - `last`: last granted source. Its reset value means in1 has priority first.
- Slot free: `slot = !out_valid || out_ready`.
- Grant, computed combinationally, only when `slot` is high:
  - If `state==OWNn`, in n_valid is high, and `bcnt < MAX_BURST`: grant n (burst continues).
  - Else, if exactly one source is valid: grant that source. This starts a new burst, even for the previous owner once the other source is idle.
  - Else, if both are valid: grant the source not equal to `last`.
  - Else: no grant.
- Readiness: in n_ready = `slot && grant==n`. At most one ready is high per cycle.
- On accept from source n (valid && ready):
  - `out_data` ← in n_data, `sel` ← n, `out_valid` ← 1.
  - Continuing burst: `bcnt` ← `bcnt`+1.
  - New burst: `state` ← OWNn, `bcnt` ← 1, `last` ← n.
- Consumer take without a new accept: `out_valid` ← 0. `out_data` and `sel` hold their values.
- Slot free but no requester valid: `state` ← IDLE, `bcnt` ← 0.
- Slot not free (`out_valid && !out_ready`): both readies are low; state, `bcnt`, `out_data`, and `sel` all hold.
- Owner drops valid mid-burst while the other source is valid: the grant switches in that same cycle. There is no idle bubble.
- MAX_BURST=1 gives strict alternation while both sources are valid.

## Timing
- Reset values (asserted asynchronously, immediately on rst_n low):
  - `out_valid`=0, `out_data`=0, `sel`=0.
  - `state`=IDLE, `bcnt`=0, `last`=1.
  - Both readies drop low combinationally.
- Latency: a word accepted at edge k appears on `out_data` with `out_valid`=1 after edge k.
- Throughput: one word per cycle when `out_ready` is held high. The take and the next accept occur in the same cycle.
- Ready depends combinationally on the valids, `out_ready`, and registered state. Valid does not depend on ready.
- Reset mid-burst: any word held in the output register is discarded. After release, the first grant goes to in1 if both sources are valid.
- `bcnt` never exceeds MAX_BURST. It saturates, then a forced switch occurs when the other source is valid.

## Test plan
- Reset check: hold rst_n=0 with arbitrary inputs -> `out_valid`=0, `out_data`=0, `sel`=0, both readies 0. Release with both sources valid -> in1_ready=1 first.
- Single stream: in1 offers 0x11111111, 0x22222222, 0x33333333 back-to-back with `out_ready`=1 -> the three words appear on consecutive cycles with `sel`=0 and no bubble. in2_ready stays 0.
- Fairness: both sources valid continuously, MAX_BURST=4, in1 words 0xA000000k, in2 words 0xB000000k -> the output order is 4×A, 4×B, 4×A, with `sel` tracking the source.
- Backpressure: `out_valid`=1 holding 0x55555555 with `out_ready`=0 for 3 cycles, both sources valid -> `out_data` is stable, `sel` is stable, both readies stay 0. When `out_ready` returns to 1, the next grant follows the rules with no lost or duplicated word.
- Early switch: in1 owns with `bcnt`=2, then in1_valid drops while in2_valid=1 -> in2_ready=1 in that same cycle. The next output is the in2 word with `sel`=1.
- Reset mid-burst: assert rst_n=0 during an in2 burst with `out_valid`=1 -> the outputs clear immediately. After release with both sources valid, in1 is granted first.

Source files
------------

// File: rtl/arb2to1_32bit.sv
// arb2to1_32bit: two-source round-robin arbiter feeding a single-entry
// registered output stage. A source that keeps winning is limited to
// MAX_BURST consecutive words while the other source is waiting.
module arb2to1_32bit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  output logic             in2_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } state_t;

  localparam logic [3:0] MAX_B = MAX_BURST[3:0];

  state_t           state_q;
  logic [3:0]       bcnt_q;
  logic             last_q;      // 0 = in1 granted last, 1 = in2
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             sel_q;

  logic slot;
  logic gnt1;
  logic gnt2;
  logic cont;
  logic acc1;
  logic acc2;

  // Grant decision: continue the current burst if allowed, otherwise
  // start a new burst with the only valid source or the one not served last.
  always_comb begin
    slot = !out_valid_q || out_ready;
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    cont = 1'b0;
    if (slot) begin
      if (state_q == OWN1 && in1_valid && bcnt_q < MAX_B) begin
        gnt1 = 1'b1;
        cont = 1'b1;
      end else if (state_q == OWN2 && in2_valid && bcnt_q < MAX_B) begin
        gnt2 = 1'b1;
        cont = 1'b1;
      end else if (in1_valid && !in2_valid) begin
        gnt1 = 1'b1;
      end else if (in2_valid && !in1_valid) begin
        gnt2 = 1'b1;
      end else if (in1_valid && in2_valid) begin
        if (last_q) gnt1 = 1'b1;
        else        gnt2 = 1'b1;
      end
    end
  end

  // Readies are gated by rst_n so they fall immediately when reset asserts,
  // not only once the registered state has cleared.
  assign in1_ready = rst_n && gnt1;
  assign in2_ready = rst_n && gnt2;
  assign acc1      = in1_valid && in1_ready;
  assign acc2      = in2_valid && in2_ready;

  // Arbitration state and output register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= 1'b0;
    end else if (acc1 || acc2) begin
      out_data_q  <= acc2 ? in2_data : in1_data;
      sel_q       <= acc2;
      out_valid_q <= 1'b1;
      if (cont) begin
        bcnt_q <= bcnt_q + 4'd1;
      end else begin
        state_q <= acc2 ? OWN2 : OWN1;
        bcnt_q  <= 4'd1;
        last_q  <= acc2;
      end
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (slot && !in1_valid && !in2_valid) begin
        state_q <= IDLE;
        bcnt_q  <= '0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_arb2to1_32bit.sv
// Directed bench for arb2to1_32bit: expected accepts are pushed to a
// scoreboard as stimulus is driven and checked when the consumer takes a word.
module tb_arb2to1_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in1_valid, in2_valid, out_ready;
  logic [31:0] in1_data, in2_data;
  logic        in1_ready, in2_ready, out_valid, sel;
  logic [31:0] out_data;

  typedef struct packed {
    logic        s;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  arb2to1_32bit #(.WIDTH(32), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .in2_valid (in2_valid),
    .in2_data  (in2_data),
    .in2_ready (in2_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs (called just after a negedge), check readies and
  // out_valid, score any take, record expected accepts, then move to the next negedge.
  task automatic step(input logic v1, input logic [31:0] d1,
                      input logic v2, input logic [31:0] d2,
                      input logic ordy, input logic er1, input logic er2,
                      input logic eov);
    exp_t e;
    in1_valid = v1; in1_data = d1;
    in2_valid = v2; in2_data = d2;
    out_ready = ordy;
    #1;
    check("in1_ready", in1_ready, er1);
    check("in2_ready", in2_ready, er2);
    check("out_valid", out_valid, eov);
    if (out_valid && out_ready) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_underflow: observed word %h expected none", out_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_data", out_data, e.d);
        check("sel", sel, e.s);
      end
    end
    if (er1) sb.push_back('{s: 1'b0, d: d1});
    if (er2) sb.push_back('{s: 1'b1, d: d2});
    @(negedge clk);
  endtask

  initial begin
    // Reset with arbitrary inputs active.
    rst_n = 1'b0;
    in1_valid = 1'b1; in1_data = 32'hDEADBEEF;
    in2_valid = 1'b1; in2_data = 32'hCAFEF00D;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sel", sel, 0);
    check("rst_in1_ready", in1_ready, 0);
    check("rst_in2_ready", in2_ready, 0);
    rst_n = 1'b1;

    // Fairness: 4 x A, 4 x B, then A again; in1 first after reset.
    step(1, 32'hA0000001, 1, 32'hB0000001, 1, 1, 0, 0);
    step(1, 32'hA0000002, 1, 32'hB0000001, 1, 1, 0, 1);
    step(1, 32'hA0000003, 1, 32'hB0000001, 1, 1, 0, 1);
    step(1, 32'hA0000004, 1, 32'hB0000001, 1, 1, 0, 1);
    step(1, 32'hA0000005, 1, 32'hB0000001, 1, 0, 1, 1);
    step(1, 32'hA0000005, 1, 32'hB0000002, 1, 0, 1, 1);
    step(1, 32'hA0000005, 1, 32'hB0000003, 1, 0, 1, 1);
    step(1, 32'hA0000005, 1, 32'hB0000004, 1, 0, 1, 1);
    step(1, 32'hA0000005, 1, 32'hB0000005, 1, 1, 0, 1);
    step(1, 32'hA0000006, 1, 32'hB0000005, 1, 1, 0, 1);
    // Early switch: in1 drops at bcnt=2, in2 granted in the same cycle.
    step(0, 32'h0,        1, 32'hB0000005, 1, 0, 1, 1);
    step(0, 32'h0,        0, 32'h0,        1, 0, 0, 1);

    // Single stream from in1, no bubbles.
    step(1, 32'h11111111, 0, 32'h0, 1, 1, 0, 0);
    step(1, 32'h22222222, 0, 32'h0, 1, 1, 0, 1);
    step(1, 32'h33333333, 0, 32'h0, 1, 1, 0, 1);
    step(1, 32'h55555555, 0, 32'h0, 1, 1, 0, 1);

    // Backpressure: 0x55555555 held for 3 cycles with both sources valid.
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h66666666, 1, 32'hC0000001, 0, 0, 0, 1);
      check("bp_out_data", out_data, 32'h55555555);
      check("bp_sel", sel, 0);
    end
    // in1 burst is saturated (bcnt=4), so in2 wins when the slot frees.
    step(1, 32'h66666666, 1, 32'hC0000001, 1, 0, 1, 1);
    step(0, 32'h0,        0, 32'h0,        1, 0, 0, 1);

    // in2 burst, then reset while a word is held.
    step(0, 32'h0, 1, 32'hD0000001, 1, 0, 1, 0);
    step(0, 32'h0, 1, 32'hD0000002, 1, 0, 1, 1);
    in1_valid = 1'b1; in1_data = 32'hE0000001;
    in2_valid = 1'b1; in2_data = 32'hF0000001;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_sel", sel, 0);
    check("mid_rst_in1_ready", in1_ready, 0);
    check("mid_rst_in2_ready", in2_ready, 0);
    sb.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(1, 32'hE0000001, 1, 32'hF0000001, 1, 1, 0, 0);
    step(0, 32'h0,        0, 32'h0,        1, 0, 0, 1);
    step(0, 32'h0,        0, 32'h0,        1, 0, 0, 0);

    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
